// File: rtl/clk_switch_pkg.sv
// Shared definitions for the clock-switch controller: FSM state encoding,
// mux source encoding and the timeout counter width helper.
package clk_switch_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_WAIT_OFF = 3'd1;
    localparam state_t ST_WAIT_ON  = 3'd2;
    localparam state_t ST_DONE     = 3'd3;
    localparam state_t ST_ERR      = 3'd4;

    localparam logic SRC_CLK0 = 1'b0;
    localparam logic SRC_CLK1 = 1'b1;

    function automatic int tmo_width(input int timeout);
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/clk_switch_ctrl_div.sv
// Even-ratio clock divider: the output toggles every DIV/2 master cycles,
// which gives a 50 % duty clock at clk/DIV.
module clk_div_even #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic clk_o
);

    localparam int HALF = DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] TERM = CW'(HALF - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_q, clk_d;

    always_comb begin
        cnt_d = cnt_q + ONE;
        clk_d = clk_q;
        if (cnt_q == TERM) begin
            cnt_d = '0;
            clk_d = ~clk_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    assign clk_o = clk_q;

endmodule

// File: rtl/clk_switch_ctrl.sv
// Master-clock-side controller for the two-clock glitch-free mux: generates
// both source clocks, drives select and tracks the mux enable flags.
// Timeout/ERR handling is built only when CLK_SWITCH_TIMEOUT_EN is defined.
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int DIV0        = 4,
    parameter int DIV1        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_req,
    input  logic       sw_tgt,
    input  logic       en0_i,
    input  logic       en1_i,
    output logic       clk0_o,
    output logic       clk1_o,
    output logic       select,
    output logic       cur_sel,
    output logic       sw_busy,
    output logic       sw_done,
    output logic       sw_err,
    output logic [2:0] dbg_state
);

    if ((DIV0 < 2) || (DIV0 % 2 != 0) || (DIV1 < 2) || (DIV1 % 2 != 0) ||
        (SYNC_STAGES < 2) || (TIMEOUT < 4)) begin : g_param_check
        $error("clk_switch_ctrl: illegal parameter value");
    end

    clk_div_even #(.DIV(DIV0)) u_div0 (.clk(clk), .rst(rst), .clk_o(clk0_o));
    clk_div_even #(.DIV(DIV1)) u_div1 (.clk(clk), .rst(rst), .clk_o(clk1_o));

    logic [SYNC_STAGES-1:0] en0_sync_q, en0_sync_d;
    logic [SYNC_STAGES-1:0] en1_sync_q, en1_sync_d;
    logic                   en0_s, en1_s, old_en, new_en, tmo_hit;

    state_t state_q, state_d;
    logic   select_q, select_d;
    logic   cur_sel_q, cur_sel_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    assign en0_sync_d = {en0_sync_q[SYNC_STAGES-2:0], en0_i};
    assign en1_sync_d = {en1_sync_q[SYNC_STAGES-2:0], en1_i};
    assign en0_s      = en0_sync_q[SYNC_STAGES-1];
    assign en1_s      = en1_sync_q[SYNC_STAGES-1];

    // Old source is the one we are leaving (cur_sel), new one is select.
    assign old_en = (cur_sel_q == SRC_CLK0) ? en0_s : en1_s;
    assign new_en = (select_q  == SRC_CLK1) ? en1_s : en0_s;

`ifdef CLK_SWITCH_TIMEOUT_EN
    localparam int TW = tmo_width(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    assign tmo_hit = (tmo_q == TMO_LAST);

    // Counts only while staying in a wait state; any transition clears it.
    always_comb begin
        tmo_d = '0;
        if ((state_d == state_q) &&
            ((state_q == ST_WAIT_OFF) || (state_q == ST_WAIT_ON))) begin
            tmo_d = tmo_q + TMO_ONE;
        end
        err_d = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign sw_err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign sw_err  = 1'b0;
`endif

    // Exit condition is tested before the timeout so it wins a tie.
    always_comb begin
        state_d   = state_q;
        select_d  = select_q;
        cur_sel_d = cur_sel_q;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (sw_req) begin
                    if (sw_tgt == cur_sel_q) begin
                        state_d = ST_DONE;
                    end else begin
                        select_d = sw_tgt;
                        busy_d   = 1'b1;
                        state_d  = ST_WAIT_OFF;
                    end
                end
            end
            ST_WAIT_OFF: begin
                if (!old_en)      state_d = ST_WAIT_ON;
                else if (tmo_hit) state_d = ST_ERR;
            end
            ST_WAIT_ON: begin
                if (new_en)       state_d = ST_DONE;
                else if (tmo_hit) state_d = ST_ERR;
            end
            ST_DONE: begin
                cur_sel_d = select_q;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            ST_ERR: begin
                select_d = cur_sel_q;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en0_sync_q <= '0;
            en1_sync_q <= '0;
            state_q    <= ST_IDLE;
            select_q   <= 1'b0;
            cur_sel_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            en0_sync_q <= en0_sync_d;
            en1_sync_q <= en1_sync_d;
            state_q    <= state_d;
            select_q   <= select_d;
            cur_sel_q  <= cur_sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign select    = select_q;
    assign cur_sel   = cur_sel_q;
    assign sw_busy   = busy_q;
    assign sw_done   = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl: divider start-up, a cycle-by-cycle
// vector table for a full switch, asynchronous reset and the timeout path.
module tb_clk_switch_ctrl;
    import clk_switch_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_req = 1'b0;
    logic       sw_tgt = 1'b0;
    logic       en0_i = 1'b1;
    logic       en1_i = 1'b0;
    logic       clk0_o, clk1_o, select, cur_sel, sw_busy, sw_done, sw_err;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       req, tgt, en0, en1;
        logic       sel, cur, busy, done;
        logic [2:0] st;
    } vec_t;

    vec_t vecs[$];

    clk_switch_ctrl #(
        .DIV0(4), .DIV1(2), .SYNC_STAGES(2), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .sw_req(sw_req), .sw_tgt(sw_tgt),
        .en0_i(en0_i), .en1_i(en1_i), .clk0_o(clk0_o), .clk1_o(clk1_o),
        .select(select), .cur_sel(cur_sel), .sw_busy(sw_busy),
        .sw_done(sw_done), .sw_err(sw_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic req, tgt, e0, e1, sel, cur, busy, done,
                       input logic [2:0] st);
        vec_t v;
        v.req = req; v.tgt = tgt; v.en0 = e0; v.en1 = e1;
        v.sel = sel; v.cur = cur; v.busy = busy; v.done = done; v.st = st;
        vecs.push_back(v);
    endtask

    initial begin
        //  req tgt e0 e1 | sel cur busy done state
        add(1, 0, 1, 0,   0, 0, 0, 1, ST_DONE);     // same target
        add(0, 0, 1, 0,   0, 0, 0, 0, ST_IDLE);
        add(1, 1, 1, 0,   1, 0, 1, 0, ST_WAIT_OFF); // switch accepted
        add(0, 0, 1, 0,   1, 0, 1, 0, ST_WAIT_OFF);
        add(0, 0, 1, 0,   1, 0, 1, 0, ST_WAIT_OFF);
        add(0, 0, 0, 0,   1, 0, 1, 0, ST_WAIT_OFF); // en0 drops
        add(0, 0, 0, 0,   1, 0, 1, 0, ST_WAIT_OFF);
        add(0, 0, 0, 0,   1, 0, 1, 0, ST_WAIT_ON);
        add(1, 0, 0, 0,   1, 0, 1, 0, ST_WAIT_ON);  // ignored request
        add(1, 1, 0, 0,   1, 0, 1, 0, ST_WAIT_ON);  // ignored request
        add(0, 0, 0, 1,   1, 0, 1, 0, ST_WAIT_ON);  // en1 rises
        add(0, 0, 0, 1,   1, 0, 1, 0, ST_WAIT_ON);
        add(0, 0, 0, 1,   1, 0, 1, 1, ST_DONE);
        add(0, 0, 0, 1,   1, 1, 0, 0, ST_IDLE);
        add(1, 1, 0, 1,   1, 1, 0, 1, ST_DONE);     // same target, no busy
        add(0, 0, 0, 1,   1, 1, 0, 0, ST_IDLE);

        // Reset state
        @(negedge clk);
        chk1("rst_select", select, 1'b0);
        chk1("rst_cur_sel", cur_sel, 1'b0);
        chk1("rst_busy", sw_busy, 1'b0);
        chk1("rst_done", sw_done, 1'b0);
        chk1("rst_err", sw_err, 1'b0);
        chk1("rst_clk0", clk0_o, 1'b0);
        chk1("rst_clk1", clk1_o, 1'b0);
        chk3("rst_state", dbg_state, ST_IDLE);
        @(negedge clk);
        rst = 1'b0;

        // Dividers: clk1 toggles every edge, clk0 every second edge from edge 2
        for (int k = 1; k <= 8; k++) begin
            logic [3:0] kk;
            step();
            kk = 4'(k);
            chk1($sformatf("clk1_edge%0d", k), clk1_o, kk[0]);
            chk1($sformatf("clk0_edge%0d", k), clk0_o, kk[1]);
        end
        chk1("idle_busy", sw_busy, 1'b0);
        chk1("idle_done", sw_done, 1'b0);
        chk1("idle_err", sw_err, 1'b0);

        // Table-driven full switch to clk1
        for (int i = 0; i < vecs.size(); i++) begin
            sw_req = vecs[i].req;
            sw_tgt = vecs[i].tgt;
            en0_i  = vecs[i].en0;
            en1_i  = vecs[i].en1;
            step();
            chk1($sformatf("v%0d_select", i), select, vecs[i].sel);
            chk1($sformatf("v%0d_cur_sel", i), cur_sel, vecs[i].cur);
            chk1($sformatf("v%0d_busy", i), sw_busy, vecs[i].busy);
            chk1($sformatf("v%0d_done", i), sw_done, vecs[i].done);
            chk1($sformatf("v%0d_err", i), sw_err, 1'b0);
            chk3($sformatf("v%0d_state", i), dbg_state, vecs[i].st);
        end
        sw_req = 1'b0;

        // Asynchronous reset in WAIT_OFF
        rst = 1'b1; en0_i = 1'b1; en1_i = 1'b0;
        step();
        rst = 1'b0;
        repeat (3) step();
        sw_req = 1'b1; sw_tgt = SRC_CLK1;
        step();
        sw_req = 1'b0;
        chk1("ar_pre_select", select, 1'b1);
        chk1("ar_pre_busy", sw_busy, 1'b1);
        chk3("ar_pre_state", dbg_state, ST_WAIT_OFF);
        step();
        #2 rst = 1'b1;
        #1;
        chk1("ar_select", select, 1'b0);
        chk1("ar_busy", sw_busy, 1'b0);
        chk3("ar_state", dbg_state, ST_IDLE);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk1("ar_no_done", sw_done, 1'b0);
            chk1("ar_no_err", sw_err, 1'b0);
            if (k == 1) rst = 1'b0;
            step();
        end
        chk3("ar_post_state", dbg_state, ST_IDLE);
        chk1("ar_post_cur_sel", cur_sel, 1'b0);

        // Timeout: en0 drops but en1 never rises
        step();
        sw_req = 1'b1; sw_tgt = SRC_CLK1;
        step();
        sw_req = 1'b0;
        en0_i  = 1'b0;
        chk1("to_select", select, 1'b1);
        for (int n = 1; n <= 12; n++) begin
            step();
            chk1($sformatf("to_done_n%0d", n), sw_done, 1'b0);
`ifdef CLK_SWITCH_TIMEOUT_EN
            if (n == 3)  chk3("to_enter_on", dbg_state, ST_WAIT_ON);
            if (n == 10) begin
                chk3("to_still_on", dbg_state, ST_WAIT_ON);
                chk1("to_no_err_yet", sw_err, 1'b0);
            end
            if (n == 11) begin
                chk3("to_err_state", dbg_state, ST_ERR);
                chk1("to_err_pulse", sw_err, 1'b1);
                chk1("to_err_busy", sw_busy, 1'b1);
            end
            if (n == 12) begin
                chk3("to_idle", dbg_state, ST_IDLE);
                chk1("to_err_end", sw_err, 1'b0);
                chk1("to_revert", select, 1'b0);
                chk1("to_busy_end", sw_busy, 1'b0);
                chk1("to_cur_sel", cur_sel, 1'b0);
            end
`else
            chk1($sformatf("to_no_err_n%0d", n), sw_err, 1'b0);
`endif
        end
`ifndef CLK_SWITCH_TIMEOUT_EN
        repeat (30) step();
        chk1("nto_busy_held", sw_busy, 1'b1);
        chk1("nto_select_held", select, 1'b1);
        chk3("nto_state", dbg_state, ST_WAIT_ON);
        chk1("nto_err", sw_err, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_switch_ctrl.md
# clk_switch_ctrl

Single-clock controller that drives the two-clock glitch-free mux. It generates both source clocks from one master clock and issues the `select` request to the mux. It then completes a switch handshake by watching the mux's per-source enable flags, `out00` and `out01`, which come back as `en0_i` and `en1_i`. It sits on the master-clock side of the mux and is the only agent allowed to change `select`.

## Interface
- `DIV0`, default 4: master-clock divide ratio for `clk0_o`; even, ≥ 2.
- `DIV1`, default 2: master-clock divide ratio for `clk1_o`; even, ≥ 2.
- `SYNC_STAGES`, default 2: synchronizer depth on `en0_i`/`en1_i`; ≥ 2.
- `TIMEOUT`, default 64: master cycles allowed per wait state; ≥ 4.
- `clk` in 1: master clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sw_req` in 1: switch request, sampled only in IDLE.
- `sw_tgt` in 1: requested source (0 = clk0, 1 = clk1), valid with `sw_req`.
- `en0_i` in 1: mux flag "clk0 path enabled", asynchronous to `clk`.
- `en1_i` in 1: mux flag "clk1 path enabled", asynchronous to `clk`.
- `clk0_o` out 1: divided clock, `clk`/DIV0, 50 % duty.
- `clk1_o` out 1: divided clock, `clk`/DIV1, 50 % duty.
- `select` out 1: registered mux select.
- `cur_sel` out 1: last successfully switched-to source.
- `sw_busy` out 1: high while a switch is in progress.
- `sw_done` out 1: one-cycle pulse, switch completed.
- `sw_err` out 1: one-cycle pulse, switch timed out.

## Operation
- Dividers:
  - Free-running counter per clock; the output toggles when the counter reaches DIV/2−1, then the counter clears.
  - Dividers run independent of FSM state.
- Enables pass through SYNC_STAGES flops (reset 0) before any use; only synchronized values are referenced below.
- FSM states: IDLE, WAIT_OFF, WAIT_ON, plus DONE and ERR (one cycle each).
- IDLE:
  - If `sw_req` and `sw_tgt == cur_sel`: go to DONE; `select` unchanged.
  - If `sw_req` and `sw_tgt != cur_sel`: `select <= sw_tgt`, `sw_busy <= 1`, go to WAIT_OFF.
- WAIT_OFF: wait until the enable of the old source (`cur_sel`) is low, then go to WAIT_ON.
- WAIT_ON: wait until the enable of the new source (`select`) is high, then go to DONE.
- DONE:
  - `sw_done = 1`, `cur_sel <= select`, `sw_busy <= 0`.
  - Return to IDLE.
- ERR:
  - `sw_err = 1`, `select <= cur_sel` (revert), `sw_busy <= 0`.
  - Return to IDLE.
- `sw_req` outside IDLE is ignored; no queueing.
- A new request is accepted no earlier than the cycle after DONE/ERR.

## Timing
- Reset values: `clk0_o`=0, `clk1_o`=0, `select`=0, `cur_sel`=0, `sw_busy`=0, `sw_done`=0, `sw_err`=0, divider counters 0, timeout counter 0, state IDLE.
- After `rst` falls, `clk1_o` first rises at edge DIV1/2 and `clk0_o` first rises at edge DIV0/2.
- `select` changes on the edge that samples the accepted `sw_req` (1-cycle latency).
- Same-target request: `sw_done` is high exactly 1 cycle after the request edge; `sw_busy` never rises.
- Flag-to-state latency: a raw enable change reaches the FSM after SYNC_STAGES edges; the transition happens on the next edge.
- `sw_done`/`sw_err` are registered, one cycle wide, and mutually exclusive.
- Timeout counter:
  - Cleared on entry to WAIT_OFF and on entry to WAIT_ON.
  - Increments each cycle in those states.
  - Reaching TIMEOUT−1 without the exit condition forces ERR on the next edge.
- If the exit condition and timeout coincide in the same cycle, the exit condition wins.
- `rst` mid-switch returns everything to reset values immediately, including `select`=0; no `sw_done`/`sw_err` is produced.

## Configuration
- `CLK_SWITCH_TIMEOUT_EN` defined: timeout counter and ERR state are present as described.
- Not defined:
  - No counter; WAIT_OFF/WAIT_ON wait indefinitely.
  - `sw_err` is tied to 0.
  - `TIMEOUT` is unused.

## Structure
- Shared package `clk_switch_pkg` holds:
  - the state enum (IDLE, WAIT_OFF, WAIT_ON, DONE, ERR);
  - the source encoding constants SRC_CLK0 = 0 and SRC_CLK1 = 1;
  - the timeout counter width function, $clog2(TIMEOUT).
- One natural sub-module, `clk_div_even`, parameterized by DIV, instantiated twice.
- Synchronizers are inline in the top.

## Test plan
- Reset release with DIV0=4, DIV1=2 → `clk1_o` period 2 clk, `clk0_o` period 4 clk, both 50 % duty; all status outputs 0.
- `sw_req`=1, `sw_tgt`=0 with `cur_sel`=0 → `sw_done` pulse 1 cycle later; `select` stays 0; `sw_busy` stays 0.
- Model the mux: `en0_i` drops 3 cycles after `select` rises, `en1_i` rises 5 cycles after that. Request `sw_tgt`=1 → `select`=1 the next cycle; then `sw_done` and `cur_sel`=1 after the flag delays plus SYNC_STAGES latency.
- With `en1_i` held 0, TIMEOUT=8, and the macro defined → `sw_err` pulse and `select` reverts to 0. Same stimulus without the macro → `sw_busy` stays 1 indefinitely.
- Second `sw_req` during WAIT_ON → ignored; exactly one `sw_done`.
- Assert `rst` during WAIT_OFF → `select`=0, `sw_busy`=0 immediately (asynchronous); no completion pulse.
